// File: rtl/control_sequencer.sv
// Multi-cycle IF/EX/WAIT control sequencer: latches and classifies the instruction, steps it
// through its execute cycles and produces constant K. Define COND_BRANCH_EN to enable the B.cond evaluator.
module control_sequencer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_STEPS  = 4,
    localparam int unsigned STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic [3:0]            status,
    input  logic                  mem_ready,
    output logic [1:0]            state,
    output logic [STEP_W-1:0]     step,
    output logic [31:0]           ir,
    output logic [2:0]            iclass,
    output logic [DATA_WIDTH-1:0] K,
    output logic                  ir_load,
    output logic                  mem_req,
    output logic                  last_step,
    output logic                  cond_pass,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        ST_IF   = 2'b00,
        ST_EX   = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        CL_DIMM   = 3'd0,
        CL_MOVZ   = 3'd1,
        CL_MOVK   = 3'd2,
        CL_BRANCH = 3'd3,
        CL_MEM    = 3'd4,
        CL_DREG   = 3'd5
    } iclass_e;

    if (MAX_STEPS < 2) begin : g_bad_max_steps
        $error("control_sequencer: MAX_STEPS must be at least 2");
    end
    if ((DATA_WIDTH < 32) || ((DATA_WIDTH % 16) != 0)) begin : g_bad_data_width
        $error("control_sequencer: DATA_WIDTH must be a multiple of 16 and at least 32");
    end

    function automatic iclass_e classify(input logic [31:0] w);
        iclass_e cls;
        if (w[27:26] == 2'b00) begin
            if (w[25:23] == 3'b101) begin
                if (w[29]) cls = CL_MOVK;
                else       cls = CL_MOVZ;
            end else begin
                cls = CL_DIMM;
            end
        end else if (w[27:26] == 2'b01) begin
            cls = CL_BRANCH;
        end else if (!w[25]) begin
            cls = CL_MEM;
        end else begin
            cls = CL_DREG;
        end
        return cls;
    endfunction

    // Returns {illegal, K} for instruction w of class cls at execute step stp.
    function automatic logic [DATA_WIDTH:0] gen_k(input logic [31:0] w, input iclass_e cls,
                                                 input logic [STEP_W-1:0] stp);
        logic [DATA_WIDTH-1:0] k;
        logic                  bad;
        int unsigned           sh;
        k   = '0;
        bad = 1'b0;
        sh  = 32'(w[22:21]) << 4;
        case (cls)
            CL_MOVZ, CL_MOVK: begin
                if ((sh + 32'd16) > DATA_WIDTH) begin
                    bad = 1'b1;
                end else if ((cls == CL_MOVK) && (stp == '0)) begin
                    k = ~(DATA_WIDTH'(16'hFFFF) << sh);
                end else begin
                    k = DATA_WIDTH'(w[20:5]) << sh;
                end
            end
            CL_MEM:  k = DATA_WIDTH'($signed(w[20:12]));
            CL_DREG: k = DATA_WIDTH'(w[15:10]);
            CL_BRANCH: begin
                if (w[26] && (w[30:29] == 2'b00)) k = DATA_WIDTH'($signed(w[25:0]));
                else                              k = DATA_WIDTH'($signed(w[23:5]));
            end
            default: k = DATA_WIDTH'(w[21:10]);
        endcase
        return {bad, k};
    endfunction

    state_e                state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [31:0]           ir_q, ir_d;
    iclass_e               iclass_q, iclass_d;
    logic [DATA_WIDTH-1:0] k_q, k_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH:0]   load_res;
    logic [DATA_WIDTH:0]   adv_res;
    logic                  is_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IF;
            step_q    <= '0;
            ir_q      <= '0;
            iclass_q  <= CL_DIMM;
            k_q       <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            ir_q      <= ir_d;
            iclass_q  <= iclass_d;
            k_q       <= k_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, constant generation and combinational handshake outputs.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ir_d      = ir_q;
        iclass_d  = iclass_q;
        k_d       = k_q;
        illegal_d = illegal_q;
        ir_load   = 1'b0;
        mem_req   = 1'b0;
        last_step = 1'b0;
        is_last   = 1'b0;
        load_res  = gen_k(instruction, classify(instruction), '0);
        adv_res   = gen_k(ir_q, iclass_q, step_q + STEP_W'(1));

        case (state_q)
            ST_IF: begin
                ir_load = 1'b1;
                if (mem_ready) begin
                    ir_d      = instruction;
                    iclass_d  = classify(instruction);
                    k_d       = load_res[DATA_WIDTH-1:0];
                    illegal_d = load_res[DATA_WIDTH];
                    step_d    = '0;
                    state_d   = ST_EX;
                end
            end
            ST_EX: begin
                if (iclass_q == CL_MOVK) is_last = (step_q == STEP_W'(1));
                else                     is_last = (step_q == '0);
                last_step = is_last;
                mem_req   = (iclass_q == CL_MEM) && (step_q == '0);
                if (is_last) begin
                    step_d = '0;
                    if (mem_req && !mem_ready) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d   = ST_IF;
                        illegal_d = 1'b0;
                    end
                end else begin
                    step_d    = step_q + STEP_W'(1);
                    k_d       = adv_res[DATA_WIDTH-1:0];
                    illegal_d = illegal_q | adv_res[DATA_WIDTH];
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d   = ST_IF;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = ST_IF;
        endcase
    end

`ifdef COND_BRANCH_EN
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] flags);
        logic v, c, n, z;
        logic res;
        {v, c, n, z} = flags;
        case (cc)
            4'b0000: res = z;
            4'b0001: res = !z;
            4'b0010: res = c;
            4'b0011: res = !c;
            4'b0100: res = n;
            4'b0101: res = !n;
            4'b0110: res = v;
            4'b0111: res = !v;
            4'b1000: res = c && !z;
            4'b1001: res = !(c && !z);
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = !z && (n == v);
            4'b1101: res = !(!z && (n == v));
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Evaluated against live flags so a branch sees status as it is this cycle.
    always_comb begin
        cond_pass = (iclass_q == CL_BRANCH) && cond_eval(ir_q[3:0], status);
    end
`else
    logic unused_status;
    assign unused_status = ^status;
    assign cond_pass     = 1'b0;
`endif

    assign state   = state_q;
    assign step    = step_q;
    assign ir      = ir_q;
    assign iclass  = iclass_q;
    assign K       = k_q;
    assign illegal = illegal_q;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle sequencer that replaces the hard-wired IF/EX0/EX1/EX2 state logic of the CPU control unit. Latches the fetched instruction and classifies it. Steps it through a per-class number of execute cycles, with a memory wait handshake. Produces a DATA_WIDTH-wide constant K and a condition-pass flag for B.cond; per-step control-word decode consumes `state`, `step`, `iclass` and `ir`.

## Interface
- DATA_WIDTH, 64: datapath/K width; multiple of 16, >= 32.
- MAX_STEPS, 4: execute steps supported; STEP_W = clog2(MAX_STEPS), min 1.

- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock, no other clock domains.
- instruction  in  32  fetched word, sampled in IF when mem_ready=1.
- status  in  4  flags {V,C,N,Z} = status[3:0].
- mem_ready  in  1  memory handshake (fetch and data).
- state  out  2  00 IF, 01 EX, 10 WAIT.
- step  out  STEP_W  execute step index.
- ir  out  32  latched instruction register.
- iclass  out  3  0 DIMM, 1 MOVZ, 2 MOVK, 3 BRANCH, 4 MEM, 5 DREG.
- K  out  DATA_WIDTH  registered constant.
- ir_load  out  1  high in IF (combinational from state).
- mem_req  out  1  high in EX step 0 of MEM and in WAIT.
- last_step  out  1  high on final EX step of current class.
- cond_pass  out  1  condition result, see Configuration.
- illegal  out  1  sticky until next IF; MOVZ/MOVK shift out of range.

## Operation
- Class decode from instruction (at IF) / ir: [27:26]=00 DIMM unless [25:23]=101 → MOVZ ([29]=0) or MOVK ([29]=1); [27:26]=01 BRANCH; [27]=1,[25]=0 MEM; [27]=1,[25]=1 DREG.
- Steps per class: MOVK 2, all others 1. MAX_STEPS < 2 is a configuration error (elaboration assertion).
- IF: hold while mem_ready=0; on mem_ready=1 load ir, iclass, compute K, go EX step 0.
- EX: step increments each cycle until last_step; then IF, except MEM: step 0 with mem_ready=1 → IF, mem_ready=0 → WAIT.
- WAIT: hold until mem_ready=1, then IF. K, ir unchanged.
- K (hw = ir[22:21], sh = 16*hw):
  - MOVZ: imm16 = ir[20:5] << sh.
  - MOVK step 0: ~(16'hFFFF << sh). MOVK step 1: imm16 << sh.
  - Shift: if sh+16 > DATA_WIDTH → K=0, illegal=1.
  - DIMM other: ir[21:10] zero-extended.
  - MEM: ir[20:12] sign-extended.
  - DREG: ir[15:10] zero-extended.
  - BRANCH: ir[26]=1,[30:29]=00 → ir[25:0] sign-extended; otherwise ir[23:5] sign-extended.
- Condition on ir[3:0]:
  - EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE its inverse, 1110/1111 always 1.
  - Combinational from ir and live status; 0 when iclass != BRANCH.

## Timing
- Reset values: state=IF, step=0, ir=0, iclass=0, K=0, illegal=0, mem_req=0, last_step=0, cond_pass=0; ir_load=1.
- Reset mid-EX/WAIT aborts immediately to the reset values.
- All outputs except ir_load, mem_req, last_step and cond_pass are registered.
- Latency, mem_ready=1 throughout: 1-step class 2 cycles/instr; MOVK 3; MEM 2 + stall cycles.
- K for step n+1 is computed from ir and next step and registered on the same edge that advances step.
- mem_ready is ignored in EX steps > 0 and in non-MEM classes.

## Configuration
- COND_BRANCH_EN defined: condition evaluator present as above.
- COND_BRANCH_EN undefined: cond_pass tied 0; B.cond falls through as NOP; status input unused.

## Test plan
- Reset, then MOVZ hw=2 imm16=0x1234, DATA_WIDTH=64 → state IF→EX→IF, K=0x0000_1234_0000_0000, 2 cycles.
- MOVK hw=1 imm16=0xBEEF → K step0=0xFFFF_FFFF_0000_FFFF, step1=0x0000_0000_BEEF_0000, last_step on step 1.
- DATA_WIDTH=32, MOVZ hw=2 → K=0, illegal=1; illegal clears at next IF.
- LDUR with mem_ready low 3 cycles after EX0 → mem_req high EX0 plus 3 WAIT cycles, IF on 4th edge after EX0.
- B.cond GT, status V=0 C=0 N=0 Z=0 → cond_pass=1; Z=1 → 0; macro undefined → 0.
- Assert reset during WAIT → all outputs return to reset values asynchronously; next instruction fetched normally.
